// File: rtl/alu_frame_controller.sv
// Byte-stream front end for an ALU: receives A5/op/A/B/CHK request frames from an
// RX FIFO, runs the ALU for one cycle and returns a RESULT/STATUS reply to a TX FIFO.
module alu_frame_controller #(
  parameter int NB_DATA        = 8,
  parameter int NB_OPCODE      = 6,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int NB_TIMEOUT     = 20
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NB_DATA-1:0]   i_data_to_read,
  input  logic                 i_fifo_rx_empty,
  input  logic                 i_fifo_tx_full,
  input  logic [NB_DATA-1:0]   i_alu_result,
  output logic                 o_fifo_rx_read,
  output logic                 o_fifo_tx_write,
  output logic [NB_DATA-1:0]   o_data_to_write,
  output logic [NB_OPCODE-1:0] o_alu_opcode,
  output logic [NB_DATA-1:0]   o_alu_op_A,
  output logic [NB_DATA-1:0]   o_alu_op_B,
  output logic                 o_busy,
  output logic                 o_frame_ok,
  output logic                 o_frame_err
);

  // state     | meaning
  // IDLE      | hunting for the 0xA5 start byte, other bytes dropped
  // GET_OP    | waiting for the opcode byte
  // GET_A     | waiting for operand A
  // GET_B     | waiting for operand B
  // GET_CHK   | waiting for the checksum byte
  // EXEC      | single cycle, ALU result latched
  // SEND_RES  | pushing RESULT byte when TX has room
  // SEND_STAT | pushing STATUS byte, frame_ok/frame_err pulse here
  typedef enum logic [2:0] {
    IDLE, GET_OP, GET_A, GET_B, GET_CHK, EXEC, SEND_RES, SEND_STAT
  } state_t;

  localparam logic [NB_DATA-1:0]    START_BYTE = NB_DATA'(8'hA5);
  localparam logic [NB_DATA-1:0]    STAT_OK    = NB_DATA'(8'h00);
  localparam logic [NB_DATA-1:0]    STAT_CHK   = NB_DATA'(8'h01);
  localparam logic [NB_DATA-1:0]    STAT_TMO   = NB_DATA'(8'h02);
  localparam logic [NB_TIMEOUT-1:0] TMO_LAST   = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  state_t                state, state_next;
  logic [NB_OPCODE-1:0]  opcode;
  logic [NB_DATA-1:0]    op_a, op_b, result, status;
  logic [NB_TIMEOUT-1:0] tmo_cnt;
  logic                  receiving, pop, push, timed_out, chk_match;

  // Strobes are gated by reset so a reset cycle never touches either FIFO.
  always_comb begin
    receiving  = (state == IDLE) || (state == GET_OP) || (state == GET_A) ||
                 (state == GET_B) || (state == GET_CHK);
    pop        = receiving && !i_fifo_rx_empty && !i_reset;
    push       = ((state == SEND_RES) || (state == SEND_STAT)) && !i_fifo_tx_full && !i_reset;
    timed_out  = receiving && (state != IDLE) && !pop && (tmo_cnt == TMO_LAST);
    chk_match  = (i_data_to_read == (NB_DATA'(opcode) ^ op_a ^ op_b));
    state_next = state;
    case (state)
      IDLE:      if (pop && (i_data_to_read == START_BYTE)) state_next = GET_OP;
      GET_OP:    if (pop) state_next = GET_A;   else if (timed_out) state_next = SEND_RES;
      GET_A:     if (pop) state_next = GET_B;   else if (timed_out) state_next = SEND_RES;
      GET_B:     if (pop) state_next = GET_CHK; else if (timed_out) state_next = SEND_RES;
      GET_CHK: begin
        if (pop)            state_next = chk_match ? EXEC : SEND_RES;
        else if (timed_out) state_next = SEND_RES;
      end
      EXEC:      state_next = SEND_RES;
      SEND_RES:  if (push) state_next = SEND_STAT;
      SEND_STAT: if (push) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= IDLE;
      opcode  <= '0;
      op_a    <= '0;
      op_b    <= '0;
      result  <= '0;
      status  <= '0;
      tmo_cnt <= '0;
    end else begin
      state <= state_next;
      if (pop) begin
        case (state)
          GET_OP:  opcode <= i_data_to_read[NB_OPCODE-1:0];
          GET_A:   op_a   <= i_data_to_read;
          GET_B:   op_b   <= i_data_to_read;
          default: ;
        endcase
      end
      if (pop || !receiving || (state == IDLE)) tmo_cnt <= '0;
      else                                      tmo_cnt <= tmo_cnt + 1'b1;
      // Error replies carry a zero RESULT so a stale value never leaks out.
      if ((state == GET_CHK) && pop && !chk_match) begin
        result <= '0;
        status <= STAT_CHK;
      end else if (timed_out) begin
        result <= '0;
        status <= STAT_TMO;
      end else if (state == EXEC) begin
        result <= i_alu_result;
        status <= STAT_OK;
      end
    end
  end

  assign o_fifo_rx_read  = pop;
  assign o_fifo_tx_write = push;
  assign o_data_to_write = (state == SEND_RES)  ? result :
                           (state == SEND_STAT) ? status : '0;
  assign o_alu_opcode    = opcode;
  assign o_alu_op_A      = op_a;
  assign o_alu_op_B      = op_b;
  assign o_busy          = (state != IDLE);
  assign o_frame_ok      = push && (state == SEND_STAT) && (status == STAT_OK);
  assign o_frame_err     = push && (state == SEND_STAT) && (status != STAT_OK);

endmodule

// File: tb/tb_alu_frame_controller.sv
// Bench for alu_frame_controller: queue-based RX/TX FIFO models, a small ALU, and a
// frame-level reference model of the expected two-byte replies.
module tb_alu_frame_controller;

  localparam int NB_DATA    = 8;
  localparam int NB_OPCODE  = 6;
  localparam int TMO        = 16;
  localparam int NB_TIMEOUT = 20;
  localparam int N_RAND     = 24;

  logic                 i_clk = 1'b0;
  logic                 i_reset;
  logic [NB_DATA-1:0]   i_data_to_read;
  logic                 i_fifo_rx_empty;
  logic                 i_fifo_tx_full;
  logic [NB_DATA-1:0]   i_alu_result;
  logic                 o_fifo_rx_read;
  logic                 o_fifo_tx_write;
  logic [NB_DATA-1:0]   o_data_to_write;
  logic [NB_OPCODE-1:0] o_alu_opcode;
  logic [NB_DATA-1:0]   o_alu_op_A;
  logic [NB_DATA-1:0]   o_alu_op_B;
  logic                 o_busy;
  logic                 o_frame_ok;
  logic                 o_frame_err;

  alu_frame_controller #(
    .NB_DATA(NB_DATA), .NB_OPCODE(NB_OPCODE),
    .TIMEOUT_CYCLES(TMO), .NB_TIMEOUT(NB_TIMEOUT)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_data_to_read(i_data_to_read), .i_fifo_rx_empty(i_fifo_rx_empty),
    .i_fifo_tx_full(i_fifo_tx_full), .i_alu_result(i_alu_result),
    .o_fifo_rx_read(o_fifo_rx_read), .o_fifo_tx_write(o_fifo_tx_write),
    .o_data_to_write(o_data_to_write), .o_alu_opcode(o_alu_opcode),
    .o_alu_op_A(o_alu_op_A), .o_alu_op_B(o_alu_op_B), .o_busy(o_busy),
    .o_frame_ok(o_frame_ok), .o_frame_err(o_frame_err)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] alu_fn(input logic [7:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    case (op)
      8'h20:   return a + b;
      8'h22:   return a - b;
      8'h24:   return a & b;
      default: return a ^ b;
    endcase
  endfunction

  assign i_alu_result = alu_fn({2'b00, o_alu_opcode}, o_alu_op_A, o_alu_op_B);

  int         compared = 0;
  int         mismatched = 0;
  int         cyc = 0;
  int         ok_cnt = 0;
  int         err_cnt = 0;
  int         last;
  int         exp_ok;
  int         exp_err;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  int         tx_cyc[$];
  int         pop_cyc[$];
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int tx_at(input int i);
    return (i < tx_q.size()) ? int'(tx_q[i]) : -1;
  endfunction

  function automatic int txc_at(input int i);
    return (i < tx_cyc.size()) ? tx_cyc[i] : -1;
  endfunction

  task automatic drive_rx();
    i_fifo_rx_empty = (rx_q.size() == 0);
    i_data_to_read  = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
  endtask

  // One clock: observe strobes mid-cycle, then apply the FIFO pop after the edge.
  task automatic tick();
    logic       rd, wr, ok, err;
    logic [7:0] d;
    @(negedge i_clk);
    rd = o_fifo_rx_read;
    wr = o_fifo_tx_write;
    ok = o_frame_ok;
    err = o_frame_err;
    d  = o_data_to_write;
    if (rd) begin
      check("rd_when_empty", i_fifo_rx_empty, 0);
      pop_cyc.push_back(cyc);
    end
    if (wr) begin
      check("wr_when_full", i_fifo_tx_full, 0);
      tx_q.push_back(d);
      tx_cyc.push_back(cyc);
      if (tx_q.size() % 2 == 0) begin
        check("ok_pulse", ok, (d == 8'h00));
        check("err_pulse", err, (d != 8'h00));
      end else begin
        check("pulse_on_result", {ok, err}, 0);
      end
    end else begin
      check("pulse_without_write", {ok, err}, 0);
    end
    if (ok) ok_cnt++;
    if (err) err_cnt++;
    @(posedge i_clk);
    #1;
    if (rd && rx_q.size() > 0) void'(rx_q.pop_front());
    cyc++;
    drive_rx();
  endtask

  task automatic run_until_tx(input string tag, input int n, input int budget);
    int i = 0;
    while (tx_q.size() < n && i < budget) begin
      tick();
      i++;
    end
    if (tx_q.size() < n) check({tag, "_tx_budget"}, tx_q.size(), n);
  endtask

  task automatic run_until_pops(input string tag, input int n, input int budget);
    int i = 0;
    while (pop_cyc.size() < n && i < budget) begin
      tick();
      i++;
    end
    if (pop_cyc.size() < n) check({tag, "_pop_budget"}, pop_cyc.size(), n);
  endtask

  task automatic clear_logs();
    tx_q.delete();
    tx_cyc.delete();
    pop_cyc.delete();
    ok_cnt  = 0;
    err_cnt = 0;
  endtask

  task automatic push_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] chk);
    rx_q.push_back(8'hA5);
    rx_q.push_back(op);
    rx_q.push_back(a);
    rx_q.push_back(b);
    rx_q.push_back(chk);
    drive_rx();
  endtask

  initial begin
    i_reset = 1'b1;
    i_fifo_tx_full = 1'b0;
    rx_q.push_back(8'h11);
    drive_rx();

    // Reset behaviour, with a byte already waiting in the RX FIFO.
    tick();
    tick();
    check("reset_busy", o_busy, 0);
    check("reset_rd", o_fifo_rx_read, 0);
    check("reset_wr", o_fifo_tx_write, 0);
    check("reset_data", o_data_to_write, 0);
    check("reset_opcode", o_alu_opcode, 0);
    check("reset_op_a", o_alu_op_A, 0);
    check("reset_op_b", o_alu_op_B, 0);
    check("reset_frame", {o_frame_ok, o_frame_err}, 0);
    check("reset_no_pop", pop_cyc.size(), 0);

    // Leading junk, then a valid add frame; exact reply latency.
    clear_logs();
    rx_q.push_back(8'h22);
    push_frame(8'h20, 8'h05, 8'h03, 8'h26);
    i_reset = 1'b0;
    run_until_tx("good", 2, 60);
    last = (pop_cyc.size() > 0) ? pop_cyc[pop_cyc.size()-1] : -100;
    check("good_pops", pop_cyc.size(), 7);
    check("good_result", tx_at(0), 8'h08);
    check("good_status", tx_at(1), 8'h00);
    check("good_res_latency", txc_at(0) - last, 2);
    check("good_stat_latency", txc_at(1) - last, 3);
    check("good_ok_cnt", ok_cnt, 1);
    check("good_err_cnt", err_cnt, 0);
    check("good_opcode", o_alu_opcode, 6'h20);
    check("good_op_a", o_alu_op_A, 8'h05);
    check("good_op_b", o_alu_op_B, 8'h03);
    repeat (4) tick();
    check("good_no_extra_tx", tx_q.size(), 2);
    check("good_idle", o_busy, 0);

    // Checksum error: no EXEC cycle, zero result, status 1.
    clear_logs();
    push_frame(8'h20, 8'h05, 8'h03, 8'h00);
    run_until_tx("chk", 2, 60);
    last = (pop_cyc.size() > 0) ? pop_cyc[pop_cyc.size()-1] : -100;
    check("chk_result", tx_at(0), 8'h00);
    check("chk_status", tx_at(1), 8'h01);
    check("chk_res_latency", txc_at(0) - last, 1);
    check("chk_stat_latency", txc_at(1) - last, 2);
    check("chk_err_cnt", err_cnt, 1);
    check("chk_ok_cnt", ok_cnt, 0);

    // Timeout after two bytes and silence.
    clear_logs();
    rx_q.push_back(8'hA5);
    rx_q.push_back(8'h20);
    drive_rx();
    run_until_tx("tmo", 2, 80);
    last = (pop_cyc.size() > 1) ? pop_cyc[1] : -100;
    check("tmo_result", tx_at(0), 8'h00);
    check("tmo_status", tx_at(1), 8'h02);
    check("tmo_res_cycle", txc_at(0) - last, TMO + 1);
    check("tmo_stat_cycle", txc_at(1) - last, TMO + 2);
    check("tmo_err_cnt", err_cnt, 1);
    check("tmo_opcode_kept", o_alu_opcode, 6'h20);

    // Gap just short of the timeout must not abort the frame.
    clear_logs();
    rx_q.push_back(8'hA5);
    rx_q.push_back(8'h20);
    rx_q.push_back(8'h05);
    drive_rx();
    run_until_pops("gap", 3, 20);
    repeat (TMO - 2) tick();
    check("gap_no_tx", tx_q.size(), 0);
    rx_q.push_back(8'h03);
    rx_q.push_back(8'h26);
    drive_rx();
    run_until_tx("gap", 2, 60);
    check("gap_result", tx_at(0), 8'h08);
    check("gap_status", tx_at(1), 8'h00);

    // TX FIFO full for 10 cycles while the RESULT byte is pending.
    clear_logs();
    i_fifo_tx_full = 1'b1;
    push_frame(8'h22, 8'h09, 8'h04, 8'h2F);
    run_until_pops("full", 5, 40);
    last = cyc - 1;
    tick();
    repeat (10) tick();
    check("full_no_write", tx_q.size(), 0);
    check("full_busy", o_busy, 1);
    i_fifo_tx_full = 1'b0;
    tick();
    check("full_res_count", tx_q.size(), 1);
    check("full_result", tx_at(0), 8'h05);
    check("full_res_cycle", txc_at(0) - last, 12);
    tick();
    check("full_status", tx_at(1), 8'h00);
    check("full_stat_cycle", txc_at(1) - last, 13);
    check("full_ok_cnt", ok_cnt, 1);

    // Reset in GET_B with the next frame already queued.
    clear_logs();
    rx_q.push_back(8'hA5);
    rx_q.push_back(8'h20);
    rx_q.push_back(8'h05);
    drive_rx();
    run_until_pops("rstb", 3, 20);
    i_reset = 1'b1;
    push_frame(8'h24, 8'h0F, 8'h3C, 8'h17);
    tick();
    tick();
    check("rstb_no_pop", pop_cyc.size(), 3);
    check("rstb_busy", o_busy, 0);
    i_reset = 1'b0;
    run_until_tx("rstb", 2, 60);
    check("rstb_pops", pop_cyc.size(), 8);
    check("rstb_result", tx_at(0), 8'h0C);
    check("rstb_status", tx_at(1), 8'h00);
    repeat (3) tick();
    check("rstb_tx_count", tx_q.size(), 2);

    // Reset while the reply is stalled: nothing of it may appear later.
    clear_logs();
    i_fifo_tx_full = 1'b1;
    push_frame(8'h20, 8'h01, 8'h01, 8'h20);
    run_until_pops("rstr", 5, 40);
    tick();
    tick();
    i_reset = 1'b1;
    i_fifo_tx_full = 1'b0;
    tick();
    i_reset = 1'b0;
    repeat (6) tick();
    check("rstr_no_tx", tx_q.size(), 0);
    check("rstr_idle", o_busy, 0);

    // Randomized frames with junk prefixes, corrupted checksums and TX back-pressure.
    clear_logs();
    exp_q.delete();
    exp_ok = 0;
    exp_err = 0;
    for (int f = 0; f < N_RAND; f++) begin
      logic [7:0] op, a, b, chk, junk;
      int         nj;
      nj = $urandom_range(0, 2);
      for (int j = 0; j < nj; j++) begin
        junk = 8'($urandom_range(0, 255));
        if (junk == 8'hA5) junk = 8'h5A;
        rx_q.push_back(junk);
      end
      case ($urandom_range(0, 3))
        0:       op = 8'h20;
        1:       op = 8'h22;
        2:       op = 8'h24;
        default: op = 8'($urandom_range(0, 63));
      endcase
      a   = 8'($urandom_range(0, 255));
      b   = 8'($urandom_range(0, 255));
      chk = op ^ a ^ b;
      if ($urandom_range(0, 3) == 0) chk = chk ^ (8'h01 << $urandom_range(0, 7));
      push_frame(op, a, b, chk);
      if (chk == (op ^ a ^ b)) begin
        exp_q.push_back(alu_fn(op, a, b));
        exp_q.push_back(8'h00);
        exp_ok++;
      end else begin
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h01);
        exp_err++;
      end
    end
    begin
      int i = 0;
      while (tx_q.size() < 2 * N_RAND && i < 4000) begin
        i_fifo_tx_full = ($urandom_range(0, 3) == 0);
        tick();
        i++;
      end
      i_fifo_tx_full = 1'b0;
      if (tx_q.size() < 2 * N_RAND) check("rand_tx_budget", tx_q.size(), 2 * N_RAND);
    end
    for (int k = 0; k < 2 * N_RAND; k++) check($sformatf("rand_byte_%0d", k), tx_at(k), exp_q[k]);
    check("rand_ok_cnt", ok_cnt, exp_ok);
    check("rand_err_cnt", err_cnt, exp_err);
    check("rand_rx_drained", rx_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_frame_controller.md
ALU_FRAME_CONTROLLER -- requirements
Module: alu_frame_controller

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 8, meaning the byte and operand width.
REQ-002 The block SHALL have parameter NB_OPCODE, default 6, meaning the ALU opcode width.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000, meaning the maximum number of idle clocks allowed between bytes of one frame.
REQ-004 The block SHALL have parameter NB_TIMEOUT, default 20, meaning the width of the timeout counter.
REQ-005 The block SHALL have port i_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port i_reset, input, 1, a synchronous active-high reset.
REQ-007 The block SHALL have port i_data_to_read, input, NB_DATA, the RX FIFO head byte (first-word-fall-through).
REQ-008 The block SHALL have port i_fifo_rx_empty, input, 1, asserted when the RX FIFO holds no byte.
REQ-009 The block SHALL have port i_fifo_tx_full, input, 1, asserted when the TX FIFO cannot accept a byte.
REQ-010 The block SHALL have port i_alu_result, input, NB_DATA, the combinational ALU result.
REQ-011 The block SHALL have port o_fifo_rx_read, output, 1, a one-cycle pop strobe for the RX FIFO.
REQ-012 The block SHALL have port o_fifo_tx_write, output, 1, a one-cycle push strobe for the TX FIFO.
REQ-013 The block SHALL have port o_data_to_write, output, NB_DATA, the byte pushed while o_fifo_tx_write is high.
REQ-014 The block SHALL have ports o_alu_opcode (NB_OPCODE), o_alu_op_A (NB_DATA) and o_alu_op_B (NB_DATA), all outputs, the registered ALU operands.
REQ-015 The block SHALL have port o_busy, output, 1, asserted in every state except IDLE.
REQ-016 The block SHALL have ports o_frame_ok and o_frame_err, both outputs, 1 bit each, one-cycle pulses marking frame completion.

Function
REQ-017 The request frame SHALL be 5 bytes: 0xA5 (start), opcode, A, B, CHK, where CHK = opcode XOR A XOR B.
REQ-018 The reply SHALL be 2 bytes, RESULT then STATUS: STATUS 0x00 = ok, 0x01 = checksum error, 0x02 = timeout; RESULT SHALL be 0x00 on any error.
REQ-019 The states SHALL be IDLE, GET_OP, GET_A, GET_B, GET_CHK, EXEC, SEND_RES and SEND_STAT.
REQ-020 In IDLE and GET_* states, when i_fifo_rx_empty=0 the block SHALL assert o_fifo_rx_read for exactly one cycle and capture i_data_to_read in that same cycle, consuming at most one byte per cycle.
REQ-021 In IDLE, a byte other than 0xA5 SHALL be popped and discarded while the state stays IDLE; 0xA5 SHALL cause a transition to GET_OP.
REQ-022 In GET_OP the block SHALL store bits [NB_OPCODE-1:0] of the byte as the opcode, and in GET_A and GET_B it SHALL store the operands; the captured values SHALL drive o_alu_* one cycle after capture and hold until overwritten by the next frame.
REQ-023 In GET_CHK the block SHALL compare the byte with the XOR of the captured fields; a match SHALL lead to EXEC and a mismatch to SEND_RES with STATUS=0x01.
REQ-024 EXEC SHALL last exactly one cycle and latch i_alu_result into the result register, then go to SEND_RES with STATUS=0x00.
REQ-025 The timeout counter SHALL clear on entry to GET_OP and on every popped byte, and SHALL increment on each cycle spent in a GET_* state without a pop.
REQ-026 When the timeout counter reaches TIMEOUT_CYCLES-1 in a GET_* state, the block SHALL go to SEND_RES with STATUS=0x02; IDLE SHALL never time out.
REQ-027 In SEND_RES and SEND_STAT, when i_fifo_tx_full=0, the block SHALL assert o_fifo_tx_write for one cycle with the byte on o_data_to_write, then advance (SEND_RES to SEND_STAT, SEND_STAT to IDLE); while i_fifo_tx_full=1 it SHALL write nothing and hold state.
REQ-028 o_frame_ok (STATUS 0x00) or o_frame_err (any other STATUS) SHALL pulse in the cycle the STATUS byte is written.
REQ-029 The block SHALL never assert o_fifo_rx_read during EXEC, SEND_RES or SEND_STAT, so bytes arriving in those states remain in the FIFO.
REQ-030 Frame-to-reply latency with non-empty and non-full FIFOs SHALL be: last byte popped at cycle t, EXEC at t+1, RESULT written at t+2, STATUS written at t+3.

Reset
REQ-031 While i_reset=1 at a clock edge, the state SHALL become IDLE, and all outputs, captured fields, the result register, STATUS and the timeout counter SHALL be set to 0.
REQ-032 A reset during any state, including mid-frame or mid-reply, SHALL abandon the frame with no further FIFO strobes, and no partial reply SHALL resume afterwards.

Verification
REQ-033 Bytes A5 20 05 03 26 with the ALU modelled as A+B SHALL produce TX 0x08 then 0x00, with o_frame_ok pulsing once and the REQ-030 latency holding.
REQ-034 Bytes A5 20 05 03 00 SHALL produce TX 0x00 then 0x01, with o_frame_err pulsing once and no EXEC cycle.
REQ-035 Bytes A5 20 followed by silence, with TIMEOUT_CYCLES=16, SHALL produce TX 0x00 then 0x02 on the 16th idle cycle.
REQ-036 Bytes 11 22 A5 20 05 03 26 SHALL pop the leading 0x11 and 0x22 silently, and the reply SHALL match REQ-033.
REQ-037 With i_fifo_tx_full held at 1 for 10 cycles during SEND_RES, there SHALL be no write during those cycles, RESULT SHALL be written the cycle after release, and STATUS the following cycle.
REQ-038 Reset asserted in GET_B, followed by a new valid frame, SHALL give no TX from the first frame and a correct reply to the second.
